// File: rtl/bitstream_pkg.sv
// Shared types and helpers for the configuration bitstream serializer.
//   serializer_state_e : IDLE (shift register empty) / SHIFT (holding a byte)
//   idx_width()        : width of the bit index for a given input beat width
package bitstream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } serializer_state_e;

    // Bits needed to index every bit of a width-bit beat (never below 1).
    function automatic int unsigned idx_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream interface shared by the byte input and bit output ports.
//   tvalid / tready : handshake
//   tdata           : DATA_WIDTH-bit payload
//   tlast           : frame boundary marker
interface axi_stream_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/bitstream_serializer.sv
// Width down-converter feeding the fabric configuration port: accepts
// IN_WIDTH-bit beats and emits them one bit per beat, keeping frame
// boundaries (input tlast lands on that beat's final bit).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   s_bytes     : IN_WIDTH-bit AXI-stream slave (byte input)
//   m_bits      : 1-bit AXI-stream master (bit output)
//   busy        : a byte is held / being shifted
//   frame_bits  : bits sent in the current or most recent frame (saturating)
//   frame_done  : one-cycle pulse after the tlast bit handshakes
module bitstream_serializer
    import bitstream_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = 8,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_stream_if.slave            s_bytes,
    axi_stream_if.master           m_bits,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] frame_bits,
    output logic                   frame_done
);

    localparam int unsigned      IDX_W    = idx_width(IN_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_WIDTH - 1);

    serializer_state_e state, state_next;
    logic [IN_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]    idx;
    logic                last_q;
    logic                new_frame_q;   // next bit handshake starts a new frame
    logic                at_last;
    logic                in_ready;
    logic                in_hs;
    logic                out_hs;
    logic                load;
    logic                shift;

    assign at_last = (idx == LAST_IDX);
    assign out_hs  = (state == SHIFT) && m_bits.tready;

    // Ready is combinational from m_bits.tready so a new byte can replace
    // the final bit in the same cycle (no bubble); held low during reset.
    assign in_ready = rst_n && ((state == IDLE) || (at_last && m_bits.tready));
    assign in_hs    = s_bytes.tvalid && in_ready;

    assign s_bytes.tready = in_ready;
    assign m_bits.tvalid  = (state == SHIFT);
    assign m_bits.tdata   = (state == SHIFT) &&
                            (MSB_FIRST ? shreg[IN_WIDTH-1] : shreg[0]);
    assign m_bits.tlast   = (state == SHIFT) && last_q && at_last;
    assign busy           = (state == SHIFT);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (in_hs) begin
                    state_next = SHIFT;
                    load       = 1'b1;
                end
            end
            SHIFT: begin
                if (out_hs) begin
                    if (!at_last) begin
                        shift = 1'b1;
                    end else if (in_hs) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            last_q      <= 1'b0;
            new_frame_q <= 1'b0;
            frame_bits  <= '0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= out_hs && m_bits.tlast;

            if (load) begin
                shreg  <= s_bytes.tdata;
                last_q <= s_bytes.tlast;
                idx    <= '0;
            end else if (shift) begin
                shreg <= MSB_FIRST ? {shreg[IN_WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg[IN_WIDTH-1:1]};
                idx   <= idx + IDX_W'(1);
            end

            // Count restarts at 1 on the first bit after a tlast bit, so the
            // final count of a frame stays readable until the next frame.
            if (out_hs) begin
                new_frame_q <= m_bits.tlast;
                if (new_frame_q) begin
                    frame_bits <= COUNT_WIDTH'(1);
                end else if (frame_bits != '1) begin
                    frame_bits <= frame_bits + COUNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bitstream_serializer.sv
// Self-checking bench: an MSB-first and an LSB-first serializer share one
// byte stream and one output ready; each has its own expected-bit queue.
module tb_bitstream_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       s_valid = 1'b0;
    logic [7:0] s_data  = '0;
    logic       s_last  = 1'b0;
    logic       m_ready = 1'b1;

    axi_stream_if #(.DATA_WIDTH(8)) sif0 ();
    axi_stream_if #(.DATA_WIDTH(1)) mif0 ();
    axi_stream_if #(.DATA_WIDTH(8)) sif1 ();
    axi_stream_if #(.DATA_WIDTH(1)) mif1 ();

    assign sif0.tvalid = s_valid;
    assign sif0.tdata  = s_data;
    assign sif0.tlast  = s_last;
    assign sif1.tvalid = s_valid;
    assign sif1.tdata  = s_data;
    assign sif1.tlast  = s_last;
    assign mif0.tready = m_ready;
    assign mif1.tready = m_ready;

    logic        busy0, busy1, done0, done1;
    logic [15:0] fbits0, fbits1;

    bitstream_serializer #(.IN_WIDTH(8), .MSB_FIRST(1'b1), .COUNT_WIDTH(16)) dut_msb (
        .clk(clk), .rst_n(rst_n), .s_bytes(sif0), .m_bits(mif0),
        .busy(busy0), .frame_bits(fbits0), .frame_done(done0)
    );

    bitstream_serializer #(.IN_WIDTH(8), .MSB_FIRST(1'b0), .COUNT_WIDTH(16)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .s_bytes(sif1), .m_bits(mif1),
        .busy(busy1), .frame_bits(fbits1), .frame_done(done1)
    );

    int tests_run = 0;
    int failures  = 0;
    int done_cnt0 = 0;

    logic [1:0] q0[$];   // {bit, tlast} expected from the MSB-first unit
    logic [1:0] q1[$];   // {bit, tlast} expected from the LSB-first unit

    task automatic push_expected(input logic [7:0] data, input logic last);
        for (int i = 0; i < 8; i++) begin
            q0.push_back({data[7-i], last && (i == 7)});
            q1.push_back({data[i],   last && (i == 7)});
        end
    endtask

    // Scoreboard and AXI hold checks for the MSB-first unit.
    logic       stall0 = 1'b0;
    logic [1:0] held0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall0 = 1'b0;
        end else begin
            logic [1:0] exp0;
            if (stall0) begin
                tests_run++;
                if (mif0.tvalid !== 1'b1 || {mif0.tdata, mif0.tlast} !== held0) begin
                    failures++;
                    $display("FAIL stall_hold_msb: got valid=%b {d,l}=%b required valid=1 {d,l}=%b",
                             mif0.tvalid, {mif0.tdata, mif0.tlast}, held0);
                end
            end
            if (mif0.tvalid && mif0.tready) begin
                tests_run++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL bit_msb: got unexpected bit {d,l}=%b required none",
                             {mif0.tdata, mif0.tlast});
                end else begin
                    exp0 = q0.pop_front();
                    if ({mif0.tdata, mif0.tlast} !== exp0) begin
                        failures++;
                        $display("FAIL bit_msb: got {d,l}=%b required %b",
                                 {mif0.tdata, mif0.tlast}, exp0);
                    end
                end
            end
            if (done0) done_cnt0++;
            stall0 = mif0.tvalid && !mif0.tready;
            held0  = {mif0.tdata, mif0.tlast};
        end
    end

    // Scoreboard for the LSB-first unit.
    always @(negedge clk) begin
        if (rst_n && mif1.tvalid && mif1.tready) begin
            logic [1:0] exp1;
            tests_run++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL bit_lsb: got unexpected bit {d,l}=%b required none",
                         {mif1.tdata, mif1.tlast});
            end else begin
                exp1 = q1.pop_front();
                if ({mif1.tdata, mif1.tlast} !== exp1) begin
                    failures++;
                    $display("FAIL bit_lsb: got {d,l}=%b required %b",
                             {mif1.tdata, mif1.tlast}, exp1);
                end
            end
        end
    end

    // Present a byte (valid stays high on return) and wait for acceptance.
    // Entered and left just after a rising edge.
    task automatic send_byte(input logic [7:0] data, input logic last);
        bit got = 1'b0;
        push_expected(data, last);
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sif0.tready) begin
                got = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!got) begin
            failures++;
            $display("FAIL accept_timeout: got tready=0 for 64 cycles required 1 (byte %h)", data);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (done0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (sif0.tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_tready: got %b required 0", sif0.tready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({mif0.tvalid, mif0.tdata, mif0.tlast, busy0, done0} !== 5'b0 || fbits0 !== 16'd0 ||
            sif0.tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got v/d/l/busy/done=%b fbits=%0d tready=%b required 00000 0 1",
                     {mif0.tvalid, mif0.tdata, mif0.tlast, busy0, done0}, fbits0, sif0.tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_byte;
        bit ok;
        int d0 = done_cnt0;
        send_byte(8'hA5, 1'b1);
        s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests_run++;
            if (mif0.tvalid !== 1'b1 || mif0.tlast !== (k == 7)) begin
                failures++;
                $display("FAIL single_timing bit%0d: got valid=%b last=%b required 1 %b",
                         k, mif0.tvalid, mif0.tlast, k == 7);
            end
        end
        wait_done(ok);
        tests_run++;
        if (!ok || fbits0 !== 16'd8 || busy0 !== 1'b0 || mif0.tvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_done: got done=%b fbits=%0d busy=%b valid=%b required 1 8 0 0",
                     ok, fbits0, busy0, mif0.tvalid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        tests_run++;
        if (done_cnt0 != d0 + 1 || fbits0 !== 16'd8) begin
            failures++;
            $display("FAIL single_pulse: got pulses=%0d fbits=%0d required 1 8",
                     done_cnt0 - d0, fbits0);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        push_expected(8'h0F, 1'b0);
        push_expected(8'hF0, 1'b1);
        s_valid = 1'b1; s_data = 8'h0F; s_last = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        s_data = 8'hF0; s_last = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            tests_run++;
            if (mif0.tvalid !== 1'b1 || sif0.tready !== (k == 7 || k == 15)) begin
                failures++;
                $display("FAIL b2b cycle%0d: got valid=%b s_tready=%b required 1 %b",
                         k, mif0.tvalid, sif0.tready, (k == 7 || k == 15));
            end
            if (k == 7) begin
                @(posedge clk); #1;
                s_valid = 1'b0;
            end
        end
        wait_done(ok);
        tests_run++;
        if (!ok || fbits0 !== 16'd16) begin
            failures++;
            $display("FAIL b2b_count: got done=%b fbits=%0d required 1 16", ok, fbits0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lsb_first;
        bit ok;
        send_byte(8'h01, 1'b1);
        s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests_run++;
            if (mif1.tdata !== 1'(k == 0) || mif0.tdata !== 1'(k == 7)) begin
                failures++;
                $display("FAIL lsb_order bit%0d: got lsb=%b msb=%b required %b %b",
                         k, mif1.tdata, mif0.tdata, k == 0, k == 7);
            end
        end
        wait_done(ok);
        tests_run++;
        if (!ok || fbits0 !== 16'd8 || fbits1 !== 16'd8 || done1 !== 1'b1) begin
            failures++;
            $display("FAIL lsb_count: got done=%b/%b fbits=%0d/%0d required 1/1 8/8",
                     ok, done1, fbits0, fbits1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        bit ok;
        bit acc = 1'b0;
        int n = 0;
        m_ready = 1'($urandom_range(0, 1));
        send_byte(8'h3C, 1'b0);
        push_expected(8'h55, 1'b1);
        s_data = 8'h55; s_last = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic exp_rdy;
            @(negedge clk);
            exp_rdy = (n == 7) && m_ready;
            tests_run++;
            if (sif0.tready !== exp_rdy) begin
                failures++;
                $display("FAIL bp_tready: got %b required %b after %0d bits", sif0.tready, exp_rdy, n);
            end
            if (mif0.tvalid && m_ready) n++;
            if (sif0.tready) acc = 1'b1;
            @(posedge clk); #1;
            m_ready = 1'($urandom_range(0, 1));
            if (acc) begin
                s_valid = 1'b0;
                break;
            end
        end
        tests_run++;
        if (!acc || n != 8) begin
            failures++;
            $display("FAIL bp_accept: got accepted=%b bits=%0d required 1 8", acc, n);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
        wait_done(ok);
        tests_run++;
        if (!ok || fbits0 !== 16'd16) begin
            failures++;
            $display("FAIL bp_count: got done=%b fbits=%0d required 1 16", ok, fbits0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_byte;
        bit ok;
        send_byte(8'hFF, 1'b0);
        s_valid = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        tests_run++;
        if (sif0.tready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_tready: got %b required 0", sif0.tready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (mif0.tvalid !== 1'b0 || busy0 !== 1'b0 || fbits0 !== 16'd0 || busy1 !== 1'b0 ||
            fbits1 !== 16'd0) begin
            failures++;
            $display("FAIL rst_mid_state: got valid=%b busy=%b/%b fbits=%0d/%0d required 0 0/0 0/0",
                     mif0.tvalid, busy0, busy1, fbits0, fbits1);
        end
        @(posedge clk); #1;
        send_byte(8'h80, 1'b1);
        s_valid = 1'b0;
        wait_done(ok);
        tests_run++;
        if (!ok || fbits0 !== 16'd8) begin
            failures++;
            $display("FAIL rst_mid_after: got done=%b fbits=%0d required 1 8", ok, fbits0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_two_frames;
        bit ok;
        int d0 = done_cnt0;
        send_byte(8'hC3, 1'b1);
        s_valid = 1'b0;
        wait_done(ok);
        tests_run++;
        if (!ok || fbits0 !== 16'd8) begin
            failures++;
            $display("FAIL frame1_count: got done=%b fbits=%0d required 1 8", ok, fbits0);
        end
        @(posedge clk); #1;
        send_byte(8'h12, 1'b0);
        @(negedge clk);
        tests_run++;
        if (fbits0 !== 16'd8) begin
            failures++;
            $display("FAIL frame2_hold: got fbits=%0d required 8", fbits0);
        end
        @(negedge clk);
        tests_run++;
        if (fbits0 !== 16'd1) begin
            failures++;
            $display("FAIL frame2_restart: got fbits=%0d required 1", fbits0);
        end
        @(posedge clk); #1;
        send_byte(8'h34, 1'b1);
        s_valid = 1'b0;
        wait_done(ok);
        tests_run++;
        if (!ok || fbits0 !== 16'd16) begin
            failures++;
            $display("FAIL frame2_count: got done=%b fbits=%0d required 1 16", ok, fbits0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (done_cnt0 != d0 + 2) begin
            failures++;
            $display("FAIL frame_pulses: got %0d required 2", done_cnt0 - d0);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_lsb_first();
        test_backpressure();
        test_reset_mid_byte();
        test_two_frames();
        tests_run++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drained: got %0d/%0d bits outstanding required 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bitstream_serializer.md
Name: bitstream_serializer

Overview:
- Width down-converter sitting directly upstream of the FPGA fabric's configuration port.
- Accepts configuration bytes on a wide AXI-stream slave.
- Emits them one bit per beat on the 1-bit AXI-stream master that drives the fabric's cfg_bitstream interface.
- Preserves frame boundaries: tlast on the input byte becomes tlast on that byte's final bit. Also reports per-frame bit count and busy status.

Parameters:
- IN_WIDTH, 8, input beat width in bits; must be ≥2.
- MSB_FIRST, 1, 1 = bit IN_WIDTH-1 of each byte is sent first; 0 = bit 0 first.
- COUNT_WIDTH, 16, width of the frame bit counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- s_bytes  axi_stream_if.slave  IN_WIDTH  byte stream in (tvalid, tready, tdata, tlast).
- m_bits  axi_stream_if.master  1  bit stream out to the fabric configuration port.
- busy  output  1  high while a bit is held or being shifted.
- frame_bits  output  COUNT_WIDTH  bits sent in the current/most recent frame.
- frame_done  output  1  single-cycle pulse on the handshake of the tlast bit.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n sampled on the rising clk edge only; no asynchronous reset.
- Reset values: m_bits.tvalid=0, m_bits.tdata=0, m_bits.tlast=0, s_bytes.tready=0 in the reset cycle, busy=0, frame_bits=0, frame_done=0.
- State machine: IDLE (shift register empty) and SHIFT (holding a byte).
  - Shift register shreg[IN_WIDTH-1:0], bit index idx (clog2(IN_WIDTH) bits), last_q flag.
- IDLE:
  - s_bytes.tready=1.
  - On s_bytes handshake: load shreg=tdata, last_q=tlast, idx=0, go to SHIFT.
  - First bit appears on m_bits the next cycle (latency 1).
- SHIFT:
  - m_bits.tvalid=1.
  - m_bits.tdata = shreg[IN_WIDTH-1] if MSB_FIRST, else shreg[0].
  - m_bits.tlast = last_q && idx==IN_WIDTH-1.
  - On m_bits handshake with idx<IN_WIDTH-1: shift toward the output end, idx++.
- Zero-bubble reload:
  - s_bytes.tready = (state==IDLE) || (idx==IN_WIDTH-1 && m_bits.tready), combinational from m_bits.tready.
  - If the final bit handshakes and a new byte handshakes in the same cycle: reload and stay in SHIFT.
  - Sustained throughput is exactly 1 bit/cycle.
  - If the final bit handshakes with no new byte: go to IDLE.
- Backpressure:
  - While m_bits.tvalid=1 and tready=0, tdata/tlast/tvalid hold stable (AXI rule).
  - tvalid never drops without a handshake.
- frame_bits:
  - Increments (saturating at all-ones) on each m_bits handshake.
  - On the handshake of the first bit following a tlast bit, it loads 1 instead of incrementing.
  - Otherwise holds its value after frame_done, so software can read the final count.
- frame_done: registered; high for the one cycle after the tlast bit handshake.
- busy = (state==SHIFT).
- Boundary conditions:
  - tlast on a byte: only its final bit carries tlast; earlier bits carry tlast=0.
  - Reset mid-byte: remaining bits are discarded, no tlast is emitted, frame_bits clears.
  - The input byte is never consumed while the final bit is stalled.

Decomposition:
- Shared package (bitstream_pkg):
  - typedef serializer_state_e {IDLE, SHIFT}.
  - Function for bit-index width, used by the parameter-dependent idx declaration.
- No sub-module required; the counter logic stays inline.
- The existing axi_stream_if is reused for both ports.

Test Plan:
1. Single byte 0xA5 with tlast=1, MSB_FIRST=1, m_bits.tready=1 → bits 1,0,1,0,0,1,0,1 on cycles 1–8 after accept; tlast only on the 8th bit; frame_done pulses once; frame_bits=8.
2. Back-to-back bytes 0x0F, 0xF0 (tlast on the second), tready constant 1 → 16 consecutive valid cycles with no bubble; s_bytes.tready=1 exactly on the cycle of bit 8; frame_bits=16.
3. MSB_FIRST=0, byte 0x01 → first output bit 1, remaining seven 0.
4. Random m_bits.tready (50%), byte 0x3C → data/tlast stable during stalls; sequence 0,0,1,1,1,1,0,0 intact; no input accepted until the last bit handshakes.
5. Reset asserted after 3 bits of 0xFF → next cycle tvalid=0, busy=0, frame_bits=0; following byte 0x80 serializes cleanly from bit 1.
6. Two frames: 1 byte with tlast, then 2 bytes with tlast → frame_bits reads 8, then restarts at 1, ending at 16; two frame_done pulses.
